// File: rtl/led_frame_loader_if.sv
// Host byte stream, frame-RAM write port and frame status for led_frame_loader.
// The loader connects through the slave modport; the host side uses master.
interface led_frame_loader_if #(
   parameter int ADDRESS_WIDTH = 13
);
   logic [7:0]               in_data;
   logic                     in_valid;
   logic                     in_ready;
   logic [ADDRESS_WIDTH-1:0] mem_addr;
   logic [7:0]               mem_data;
   logic                     mem_write_enable;
   logic                     frame_done;
   logic                     frame_ok;
   logic                     frame_timeout;

   modport master (
      output in_data, in_valid,
      input  in_ready, mem_addr, mem_data, mem_write_enable,
             frame_done, frame_ok, frame_timeout
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, mem_addr, mem_data, mem_write_enable,
             frame_done, frame_ok, frame_timeout
   );
endinterface

// File: rtl/led_frame_loader.sv
// Parses SYNC/length/payload/checksum frames from a byte stream and writes the
// payload into the LED frame RAM, pulsing done/ok or timeout per frame.
module led_frame_loader #(
   parameter int         MAX_LEDS          = 200,
   parameter int         NUM_CHANNELS      = 3,
   parameter int         MAX_CHANNEL_INDEX = MAX_LEDS * NUM_CHANNELS,
   parameter int         ADDRESS_WIDTH     = 13,
   parameter int         BASE_ADDRESS      = 0,
   parameter logic [7:0] SYNC_BYTE         = 8'hA5,
   parameter int         IDLE_TIMEOUT      = 50000
) (
   input  logic             clk,
   input  logic             rst,
   led_frame_loader_if.slave bus
);
   localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

   typedef enum logic [2:0] {HUNT, LEN_HI, LEN_LO, PAYLOAD, CHECKSUM} state_t;

   state_t                   r_state, w_state_next;
   logic [15:0]              r_len, r_idx;
   logic [7:0]               r_sum;
   logic [IDLE_W-1:0]        r_idle;
   logic [ADDRESS_WIDTH-1:0] r_addr;
   logic [7:0]               r_data;
   logic                     r_we, r_done, r_ok, r_timeout;

   logic                     w_accept, w_idle_hit, w_in_range;
   logic [15:0]              w_len;
   logic                     w_we, w_done, w_ok;
   logic [ADDRESS_WIDTH-1:0] w_addr;

   assign bus.in_ready         = !rst;
   assign bus.mem_addr         = r_addr;
   assign bus.mem_data         = r_data;
   assign bus.mem_write_enable = r_we;
   assign bus.frame_done       = r_done;
   assign bus.frame_ok         = r_ok;
   assign bus.frame_timeout    = r_timeout;

   assign w_accept   = bus.in_valid && !rst;
   assign w_len      = {r_len[15:8], bus.in_data};
   assign w_in_range = r_idx < 16'(MAX_CHANNEL_INDEX);
   // An accepted byte on the would-be timeout edge suppresses the timeout.
   assign w_idle_hit = (r_state != HUNT) && !w_accept &&
                       (r_idle == IDLE_W'(IDLE_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= HUNT;
         r_len     <= '0;
         r_idx     <= '0;
         r_sum     <= '0;
         r_idle    <= '0;
         r_addr    <= ADDRESS_WIDTH'(BASE_ADDRESS);
         r_data    <= '0;
         r_we      <= 1'b0;
         r_done    <= 1'b0;
         r_ok      <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_we      <= w_we;
         r_addr    <= w_addr;
         r_done    <= w_done;
         r_ok      <= w_ok;
         r_timeout <= w_idle_hit;
         if (w_we) r_data <= bus.in_data;
         if (w_accept || r_state == HUNT || w_idle_hit) r_idle <= '0;
         else                                           r_idle <= r_idle + 1'b1;
         if (w_accept) begin
            case (r_state)
               HUNT: if (bus.in_data == SYNC_BYTE) begin
                  r_sum <= '0;
                  r_idx <= '0;
               end
               LEN_HI: begin
                  r_len[15:8] <= bus.in_data;
                  r_sum       <= r_sum + bus.in_data;
               end
               LEN_LO: begin
                  r_len <= w_len;
                  r_sum <= r_sum + bus.in_data;
               end
               PAYLOAD: begin
                  r_sum <= r_sum + bus.in_data;
                  r_idx <= r_idx + 16'd1;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (w_idle_hit) begin
         w_state_next = HUNT;
      end else if (w_accept) begin
         case (r_state)
            HUNT:     if (bus.in_data == SYNC_BYTE) w_state_next = LEN_HI;
            LEN_HI:   w_state_next = LEN_LO;
            LEN_LO:   w_state_next = (w_len == 16'd0) ? CHECKSUM : PAYLOAD;
            PAYLOAD:  if (r_idx == r_len - 16'd1) w_state_next = CHECKSUM;
            CHECKSUM: w_state_next = HUNT;
            default:  w_state_next = HUNT;
         endcase
      end
   end

   always_comb begin
      w_we   = 1'b0;
      w_addr = r_addr;
      w_done = 1'b0;
      w_ok   = 1'b0;
      if (w_accept) begin
         case (r_state)
            PAYLOAD: if (w_in_range) begin
               w_we   = 1'b1;
               w_addr = ADDRESS_WIDTH'(BASE_ADDRESS) + ADDRESS_WIDTH'(r_idx);
            end
            CHECKSUM: begin
               w_done = 1'b1;
               w_ok   = (bus.in_data == r_sum) && (r_len <= 16'(MAX_CHANNEL_INDEX));
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_led_frame_loader.sv
// Randomized frame-level bench for led_frame_loader: expected writes, done/ok and
// timeout pulses are queued per accepted byte and checked every cycle.
module tb_led_frame_loader;
   localparam int TO   = 40;
   localparam int MAXI = 600;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   edge_cnt = 0;
   int   checks = 0;
   int   errors = 0;

   typedef struct { int e; logic [12:0] a; logic [7:0] d; } wr_t;
   typedef struct { int e; logic ok; } dn_t;

   wr_t wq[$];
   dn_t dq[$];
   int  tq[$];
   logic [7:0] pl [0:1023];

   led_frame_loader_if #(.ADDRESS_WIDTH(13)) bus ();

   led_frame_loader #(.IDLE_TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
      end
   endtask

   // Expected outputs for the cycle after edge e come from the event queues.
   always @(negedge clk) begin
      int  e;
      logic xw, xd, xt;
      e = edge_cnt;
      while (wq.size() > 0 && wq[0].e < e) void'(wq.pop_front());
      while (dq.size() > 0 && dq[0].e < e) void'(dq.pop_front());
      while (tq.size() > 0 && tq[0] < e)   void'(tq.pop_front());
      xw = (wq.size() > 0 && wq[0].e == e);
      xd = (dq.size() > 0 && dq[0].e == e);
      xt = (tq.size() > 0 && tq[0] == e);
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, !rst});
      chk("mem_write_enable", {31'd0, bus.mem_write_enable}, {31'd0, xw});
      if (xw) begin
         chk("mem_addr", {19'd0, bus.mem_addr}, {19'd0, wq[0].a});
         chk("mem_data", {24'd0, bus.mem_data}, {24'd0, wq[0].d});
         void'(wq.pop_front());
      end
      chk("frame_done", {31'd0, bus.frame_done}, {31'd0, xd});
      if (xd) begin
         chk("frame_ok", {31'd0, bus.frame_ok}, {31'd0, dq[0].ok});
         void'(dq.pop_front());
      end
      chk("frame_timeout", {31'd0, bus.frame_timeout}, {31'd0, xt});
      if (xt) void'(tq.pop_front());
   end

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) begin
         bus.in_data = 8'($urandom);
         @(posedge clk);
         #1;
      end
   endtask

   // Returns the edge at which the byte was accepted.
   task automatic send_byte(input logic [7:0] b, input int gap, output int e);
      idle(gap);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      @(posedge clk);
      #1;
      e = edge_cnt;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_frame(input int len, input bit use_ck, input logic [7:0] ck_in,
                             input int gapmax, input int slow_at, output logic [7:0] ck);
      int e;
      logic [7:0] b;
      ck = 8'(len >> 8) + 8'(len);
      for (int i = 0; i < len; i++) ck = ck + pl[i];
      send_byte(8'hA5, $urandom_range(gapmax), e);
      send_byte(8'(len >> 8), $urandom_range(gapmax), e);
      send_byte(8'(len), $urandom_range(gapmax), e);
      for (int i = 0; i < len; i++) begin
         send_byte(pl[i], (slow_at == i) ? TO - 1 : $urandom_range(gapmax), e);
         if (i < MAXI) wq.push_back('{e, 13'(i), pl[i]});
      end
      b = use_ck ? ck_in : ck;
      send_byte(b, (slow_at == len) ? TO - 1 : $urandom_range(gapmax), e);
      dq.push_back('{e, (b == ck) && (len <= MAXI)});
   endtask

   initial begin
      int e;
      logic [7:0] ck, g;
      int len;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("reset mem_addr", {19'd0, bus.mem_addr}, 32'd0);
      chk("reset mem_data", {24'd0, bus.mem_data}, 32'd0);
      rst = 1'b0;
      idle(2);

      // A5 00 03 11 22 33 69
      pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
      send_frame(3, 1'b0, 8'h00, 0, -1, ck);
      chk("model ck frameA", {24'd0, ck}, 32'h69);
      idle(3);
      send_frame(3, 1'b1, 8'h00, 0, -1, ck);
      chk("model ck frameB", {24'd0, ck}, 32'h69);
      idle(3);

      // Leading garbage then an empty frame
      send_byte(8'h00, 0, e);
      send_byte(8'hFF, 0, e);
      send_frame(0, 1'b0, 8'h00, 0, -1, ck);
      chk("model ck empty", {24'd0, ck}, 32'h00);
      idle(3);

      // Oversized frame: only the first MAXI bytes are written
      for (int i = 0; i < 602; i++) pl[i] = 8'h01;
      send_frame(602, 1'b0, 8'h00, 0, -1, ck);
      chk("model ck 602", {24'd0, ck}, 32'hB6);
      idle(3);
      for (int n = 599; n <= 601; n++) begin
         for (int i = 0; i < n; i++) pl[i] = 8'($urandom);
         send_frame(n, 1'b0, 8'h00, 1, -1, ck);
         idle(2);
      end

      // Partial frame abandoned after TO idle cycles
      send_byte(8'hA5, 0, e);
      send_byte(8'h00, 0, e);
      send_byte(8'h04, 0, e);
      send_byte(8'h01, 0, e);
      wq.push_back('{e, 13'd0, 8'h01});
      send_byte(8'h02, 0, e);
      wq.push_back('{e, 13'd1, 8'h02});
      tq.push_back(e + TO);
      idle(TO + 5);
      pl[0] = 8'h5C; pl[1] = 8'hA5;
      send_frame(2, 1'b0, 8'h00, 2, -1, ck);
      idle(3);

      // A gap of TO-1 idle cycles inside a frame must not time out
      pl[0] = 8'h33; pl[1] = 8'h44; pl[2] = 8'h55;
      send_frame(3, 1'b0, 8'h00, 0, 1, ck);
      send_frame(3, 1'b0, 8'h00, 0, 3, ck);
      idle(3);

      // Reset mid-frame, then a fresh frame
      send_byte(8'hA5, 0, e);
      send_byte(8'h00, 0, e);
      send_byte(8'h02, 0, e);
      send_byte(8'h07, 0, e);
      wq.push_back('{e, 13'd0, 8'h07});
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midreset mem_data", {24'd0, bus.mem_data}, 32'd0);
      chk("midreset mem_addr", {19'd0, bus.mem_addr}, 32'd0);
      rst = 1'b0;
      idle(TO + 5);
      pl[0] = 8'h09;
      send_frame(1, 1'b0, 8'h00, 0, -1, ck);
      chk("model ck 09", {24'd0, ck}, 32'h0A);
      idle(3);

      // Random traffic
      for (int f = 0; f < 40; f++) begin
         for (int k = 0; k < int'($urandom_range(2)); k++) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h00;
            send_byte(g, $urandom_range(2), e);
         end
         len = $urandom_range(20);
         for (int i = 0; i < len; i++)
            pl[i] = ($urandom_range(7) == 0) ? 8'hA5 : 8'($urandom);
         send_frame(len, ($urandom_range(3) == 0), 8'($urandom), 3,
                    ($urandom_range(4) == 0) ? int'($urandom_range(len)) : -1, ck);
         if (f % 10 == 5) begin
            send_byte(8'hA5, 0, e);
            send_byte(8'h00, 1, e);
            tq.push_back(e + TO);
            idle(TO + 3);
         end
         idle($urandom_range(3));
      end

      idle(TO + 5);
      chk("writes left", wq.size(), 32'd0);
      chk("dones left", dq.size(), 32'd0);
      chk("timeouts left", tq.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/led_frame_loader.md
# led_frame_loader

Byte-stream frame parser that fills the LED channel memory read by the strip driver. It accepts framed pixel data from the host link (UART/SPI byte receiver) over a valid/ready handshake and validates the header, length and checksum. It writes payload bytes into the dual-port frame RAM at BASE_ADDRESS onward, and reports each completed frame with a status pulse.

## Interface
- MAX_LEDS, 200: LEDs on the strip.
- NUM_CHANNELS, 3: bytes per LED.
- MAX_CHANNEL_INDEX, MAX_LEDS*NUM_CHANNELS: payload bytes that fit in memory (600).
- ADDRESS_WIDTH, 13: memory address width.
- BASE_ADDRESS, 0: address of payload byte 0.
- SYNC_BYTE, 8'hA5: frame start marker.
- IDLE_TIMEOUT, 50000: idle cycles allowed between bytes inside a frame.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  received byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept; a byte transfers on a posedge with in_valid && in_ready.
- mem_addr  out  ADDRESS_WIDTH  write address.
- mem_data  out  8  write data.
- mem_write_enable  out  1  one-cycle write strobe.
- frame_done  out  1  one-cycle pulse after the checksum byte is accepted.
- frame_ok  out  1  valid only with frame_done: checksum matched and length <= MAX_CHANNEL_INDEX.
- frame_timeout  out  1  one-cycle pulse when a partial frame is abandoned.

## Operation
- States: HUNT, LEN_HI, LEN_LO, PAYLOAD, CHECKSUM.
- HUNT: accepted bytes other than SYNC_BYTE are discarded. SYNC_BYTE moves the FSM to LEN_HI and clears the checksum accumulator and byte index.
- LEN_HI/LEN_LO: capture the 16-bit big-endian payload length. Both bytes are added to the accumulator. After LEN_LO, length 0 goes to CHECKSUM; any other length goes to PAYLOAD.
- PAYLOAD: each accepted byte is added to the accumulator.
  - If index < MAX_CHANNEL_INDEX, the byte is written to BASE_ADDRESS+index.
  - Otherwise the byte is consumed, summed and not written.
  - index increments per byte. The FSM goes to CHECKSUM after byte length-1.
- CHECKSUM: accepted byte is compared to the accumulator (8-bit sum, mod 256, of len_hi, len_lo and all payload bytes). frame_done pulses; frame_ok = match && length <= MAX_CHANNEL_INDEX. FSM returns to HUNT.
- A SYNC_BYTE value inside a frame is ordinary data; there is no resynchronisation mid-frame.
- Timeout: an idle counter clears on every accepted byte and increments each cycle without one while not in HUNT. When it reaches IDLE_TIMEOUT, frame_timeout pulses, the FSM goes to HUNT and the counter clears. No frame_done is generated. Memory already written is not rolled back.
- A byte accepted in the same cycle the count would reach IDLE_TIMEOUT wins: the byte is processed and there is no timeout.
- in_ready = !rst. The loader never back-pressures outside reset.

## Timing
- Reset values: mem_addr=BASE_ADDRESS, mem_data=0, mem_write_enable=0, frame_done=0, frame_ok=0, frame_timeout=0. State is HUNT, counters are 0.
- Payload byte accepted at edge N drives mem_write_enable=1 with registered mem_addr/mem_data during cycle N+1 (edge N to N+1). The strobe drops at edge N+1 unless another payload byte is accepted at edge N+1. Back-to-back bytes therefore give back-to-back writes.
- Checksum byte accepted at edge N: frame_done (and frame_ok) high during cycle N+1 only.
- Timeout pulse is high for exactly one cycle following the edge where the counter reaches IDLE_TIMEOUT.
- The index counter is 16 bits. The address adder is ADDRESS_WIDTH bits, computed only for index < MAX_CHANNEL_INDEX, so it never wraps.
- rst asserted mid-frame: on the next edge all outputs return to reset values. The partial frame is dropped with no done or timeout pulse.

## Test plan
- Stream A5 00 03 11 22 33 69 -> writes 11@0, 22@1, 33@2 on consecutive cycles; frame_done=1, frame_ok=1.
- Same frame with checksum 00 -> identical writes; frame_done=1, frame_ok=0.
- Bytes 00 FF A5 00 00 00 -> leading garbage ignored; no writes; frame_done with frame_ok=1.
- Length 602 (A5 02 5A) with payload 602×01 and correct checksum -> writes only addresses 0..599; frame_ok=0.
- A5 00 04 01 02, then IDLE_TIMEOUT idle cycles -> frame_timeout pulse, no frame_done. A following valid frame completes with frame_ok=1.
- rst pulsed after A5 00 02 07 -> outputs reset next cycle, no done pulse. A new frame A5 00 01 09 0A completes with write 09@0 and frame_ok=1.
